// File: rtl/axi_lite_master_arbiter.sv
// Shares one AXI-Lite master port between two single-beat register requesters.
// Arbitrates in IDLE, runs the AW/W/B or AR/R handshake, then pulses the winner's ack.
module axi_lite_master_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        axi_lite_aclk,
    input  logic        axi_lite_aresetn,
    input  logic        req0_valid,
    input  logic        req0_write,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    output logic        req0_ack,
    input  logic        req1_valid,
    input  logic        req1_write,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        req1_ack,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        busy,
    output logic        grant,
    output logic [2:0]  dbg_state,
    output logic [31:0] axi_lite_awaddr,
    output logic [2:0]  axi_lite_awprot,
    output logic        axi_lite_awvalid,
    input  logic        axi_lite_awready,
    output logic [31:0] axi_lite_wdata,
    output logic [3:0]  axi_lite_wstrb,
    output logic        axi_lite_wvalid,
    input  logic        axi_lite_wready,
    input  logic [1:0]  axi_lite_bresp,
    input  logic        axi_lite_bvalid,
    output logic        axi_lite_bready,
    output logic [31:0] axi_lite_araddr,
    output logic [2:0]  axi_lite_arprot,
    output logic        axi_lite_arvalid,
    input  logic        axi_lite_arready,
    input  logic [31:0] axi_lite_rdata,
    input  logic [1:0]  axi_lite_rresp,
    input  logic        axi_lite_rvalid,
    output logic        axi_lite_rready
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_AW_W = 3'd1,
        S_WR_B    = 3'd2,
        S_RD_AR   = 3'd3,
        S_RD_R    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t      state_q;
    logic        last_grant_q, grant_q, busy_q, ack0_q, ack1_q;
    logic        awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic [31:0] awaddr_q, wdata_q, araddr_q, rsp_rdata_q;
    logic [1:0]  rsp_resp_q;

    logic        pick_any_d, pick_idx_d, pick_write_d, wr_done_d;
    logic [31:0] pick_addr_d, pick_wdata_d;

    always_comb begin
        pick_any_d = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            pick_idx_d = FIXED_PRIO ? 1'b0 : ~last_grant_q;
        end else begin
            pick_idx_d = ~req0_valid;
        end
        pick_write_d = pick_idx_d ? req1_write : req0_write;
        pick_addr_d  = pick_idx_d ? req1_addr  : req0_addr;
        pick_wdata_d = pick_idx_d ? req1_wdata : req0_wdata;
        // A channel whose valid already dropped has completed its beat.
        wr_done_d = (!awvalid_q || axi_lite_awready) && (!wvalid_q || axi_lite_wready);
    end

    // Handshake: a beat transfers on a rising edge with valid & ready both high; valids
    // only fall after their own handshake and ready never feeds valid combinationally.
    always_ff @(posedge axi_lite_aclk or negedge axi_lite_aresetn) begin
        if (!axi_lite_aresetn) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            busy_q       <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awaddr_q     <= 32'h0;
            wdata_q      <= 32'h0;
            araddr_q     <= 32'h0;
            rsp_rdata_q  <= 32'h0;
            rsp_resp_q   <= 2'b00;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pick_any_d) begin
                        grant_q      <= pick_idx_d;
                        last_grant_q <= pick_idx_d;
                        busy_q       <= 1'b1;
                        if (pick_write_d) begin
                            awaddr_q  <= pick_addr_d;
                            wdata_q   <= pick_wdata_d;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= S_WR_AW_W;
                        end else begin
                            araddr_q  <= pick_addr_d;
                            arvalid_q <= 1'b1;
                            state_q   <= S_RD_AR;
                        end
                    end
                end
                S_WR_AW_W: begin
                    if (awvalid_q && axi_lite_awready) awvalid_q <= 1'b0;
                    if (wvalid_q && axi_lite_wready) wvalid_q <= 1'b0;
                    if (wr_done_d) begin
                        bready_q <= 1'b1;
                        state_q  <= S_WR_B;
                    end
                end
                S_WR_B: begin
                    if (axi_lite_bvalid) begin
                        rsp_resp_q  <= axi_lite_bresp;
                        rsp_rdata_q <= 32'h0;
                        bready_q    <= 1'b0;
                        ack0_q      <= ~grant_q;
                        ack1_q      <= grant_q;
                        state_q     <= S_DONE;
                    end
                end
                S_RD_AR: begin
                    if (axi_lite_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_RD_R;
                    end
                end
                S_RD_R: begin
                    if (axi_lite_rvalid) begin
                        rsp_rdata_q <= axi_lite_rdata;
                        rsp_resp_q  <= axi_lite_rresp;
                        rready_q    <= 1'b0;
                        ack0_q      <= ~grant_q;
                        ack1_q      <= grant_q;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req0_ack         = ack0_q;
    assign req1_ack         = ack1_q;
    assign rsp_rdata        = rsp_rdata_q;
    assign rsp_resp         = rsp_resp_q;
    assign busy             = busy_q;
    assign grant            = grant_q;
    assign dbg_state        = state_q;
    assign axi_lite_awaddr  = awaddr_q;
    assign axi_lite_awprot  = 3'b000;
    assign axi_lite_awvalid = awvalid_q;
    assign axi_lite_wdata   = wdata_q;
    assign axi_lite_wstrb   = 4'hF;
    assign axi_lite_wvalid  = wvalid_q;
    assign axi_lite_bready  = bready_q;
    assign axi_lite_araddr  = araddr_q;
    assign axi_lite_arprot  = 3'b000;
    assign axi_lite_arvalid = arvalid_q;
    assign axi_lite_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_master_arbiter.sv
// Bench for axi_lite_master_arbiter: a round-robin instance with a stallable slave and a
// fixed-priority instance with a zero-wait slave, checked through per-requester queues.
module tb_axi_lite_master_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Requester side, index = instance*2 + requester
    logic [3:0]  rv, rw;
    logic [31:0] raddr [4];
    logic [31:0] rwd [4];
    logic        a00, a01, a10, a11;
    logic [3:0]  ack_v;
    assign ack_v = {a11, a10, a01, a00};

    // Instance 0 (round-robin) bus
    logic [31:0] rsp_rdata, awaddr, wdata, araddr, rdata;
    logic [1:0]  rsp_resp, bresp, rresp;
    logic [2:0]  dbg_state, awprot, arprot;
    logic [3:0]  wstrb;
    logic        busy, grant, awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;

    // Instance 1 (fixed priority) bus
    logic [31:0] p_rsp_rdata, p_awaddr, p_wdata, p_araddr, p_rdata;
    logic [1:0]  p_rsp_resp, p_bresp, p_rresp;
    logic [2:0]  p_dbg_state, p_awprot, p_arprot;
    logic [3:0]  p_wstrb;
    logic        p_busy, p_grant, p_awvalid, p_awready, p_wvalid, p_wready, p_bvalid, p_bready;
    logic        p_arvalid, p_arready, p_rvalid, p_rready;

    axi_lite_master_arbiter #(.FIXED_PRIO(1'b0)) u_dut0 (
        .axi_lite_aclk(clk), .axi_lite_aresetn(rst_n),
        .req0_valid(rv[0]), .req0_write(rw[0]), .req0_addr(raddr[0]), .req0_wdata(rwd[0]), .req0_ack(a00),
        .req1_valid(rv[1]), .req1_write(rw[1]), .req1_addr(raddr[1]), .req1_wdata(rwd[1]), .req1_ack(a01),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy), .grant(grant), .dbg_state(dbg_state),
        .axi_lite_awaddr(awaddr), .axi_lite_awprot(awprot), .axi_lite_awvalid(awvalid), .axi_lite_awready(awready),
        .axi_lite_wdata(wdata), .axi_lite_wstrb(wstrb), .axi_lite_wvalid(wvalid), .axi_lite_wready(wready),
        .axi_lite_bresp(bresp), .axi_lite_bvalid(bvalid), .axi_lite_bready(bready),
        .axi_lite_araddr(araddr), .axi_lite_arprot(arprot), .axi_lite_arvalid(arvalid), .axi_lite_arready(arready),
        .axi_lite_rdata(rdata), .axi_lite_rresp(rresp), .axi_lite_rvalid(rvalid), .axi_lite_rready(rready)
    );

    axi_lite_master_arbiter #(.FIXED_PRIO(1'b1)) u_dut1 (
        .axi_lite_aclk(clk), .axi_lite_aresetn(rst_n),
        .req0_valid(rv[2]), .req0_write(rw[2]), .req0_addr(raddr[2]), .req0_wdata(rwd[2]), .req0_ack(a10),
        .req1_valid(rv[3]), .req1_write(rw[3]), .req1_addr(raddr[3]), .req1_wdata(rwd[3]), .req1_ack(a11),
        .rsp_rdata(p_rsp_rdata), .rsp_resp(p_rsp_resp), .busy(p_busy), .grant(p_grant), .dbg_state(p_dbg_state),
        .axi_lite_awaddr(p_awaddr), .axi_lite_awprot(p_awprot), .axi_lite_awvalid(p_awvalid), .axi_lite_awready(p_awready),
        .axi_lite_wdata(p_wdata), .axi_lite_wstrb(p_wstrb), .axi_lite_wvalid(p_wvalid), .axi_lite_wready(p_wready),
        .axi_lite_bresp(p_bresp), .axi_lite_bvalid(p_bvalid), .axi_lite_bready(p_bready),
        .axi_lite_araddr(p_araddr), .axi_lite_arprot(p_arprot), .axi_lite_arvalid(p_arvalid), .axi_lite_arready(p_arready),
        .axi_lite_rdata(p_rdata), .axi_lite_rresp(p_rresp), .axi_lite_rvalid(p_rvalid), .axi_lite_rready(p_rready)
    );

    // Stallable slave for instance 0
    int          aw_dly = 0, w_dly = 0, ar_dly = 0;
    int          aw_cnt, w_cnt, ar_cnt;
    int          aw_beats = 0, w_beats = 0;
    logic        aw_seen, w_seen;
    logic [1:0]  b_cfg = 2'b00, r_cfg = 2'b00;
    logic [31:0] rd_cfg = 32'h0;

    assign awready = awvalid && (aw_cnt >= aw_dly);
    assign wready  = wvalid && (w_cnt >= w_dly);
    assign arready = arvalid && (ar_cnt >= ar_dly);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
            aw_seen <= 1'b0; w_seen <= 1'b0;
            bvalid <= 1'b0; bresp <= 2'b00;
            rvalid <= 1'b0; rdata <= 32'h0; rresp <= 2'b00;
        end else begin
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
            ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
            if (awvalid && awready) aw_beats <= aw_beats + 1;
            if (wvalid && wready) w_beats <= w_beats + 1;
            if (bvalid && bready) bvalid <= 1'b0;
            if ((aw_seen || (awvalid && awready)) && (w_seen || (wvalid && wready))) begin
                bvalid <= 1'b1; bresp <= b_cfg;
                aw_seen <= 1'b0; w_seen <= 1'b0;
            end else begin
                aw_seen <= aw_seen || (awvalid && awready);
                w_seen  <= w_seen || (wvalid && wready);
            end
            if (arvalid && arready) begin
                rvalid <= 1'b1; rdata <= rd_cfg; rresp <= r_cfg;
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
        end
    end

    // Zero-wait slave for instance 1
    assign p_awready = 1'b1;
    assign p_wready  = 1'b1;
    assign p_arready = 1'b1;
    assign p_bresp   = 2'b00;
    assign p_rresp   = 2'b00;
    assign p_rdata   = 32'h0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_bvalid <= 1'b0; p_rvalid <= 1'b0;
        end else begin
            if (p_awvalid) p_bvalid <= 1'b1; else if (p_bready) p_bvalid <= 1'b0;
            if (p_arvalid) p_rvalid <= 1'b1; else if (p_rready) p_rvalid <= 1'b0;
        end
    end

    // Scoreboard
    logic [33:0] exp_q0[$], exp_q1[$];
    logic [31:0] exp_aw_q[$], exp_w_q[$], exp_ar_q[$];
    logic        ack_log[$], p_log[$];
    int          n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic        aw_pend = 1'b0, w_pend = 1'b0, ar_pend = 1'b0;
    logic [31:0] aw_prev, w_prev, ar_prev;
    int          ar_stall = 0;
    logic [33:0] e;

    always @(negedge clk) begin
        if (!rst_n) begin
            aw_pend <= 1'b0; w_pend <= 1'b0; ar_pend <= 1'b0;
        end else begin
            if (a00 && a01) check("dual_ack", 1, 0);
            if (a00) begin
                ack_log.push_back(1'b0);
                if (exp_q0.size() == 0) check("unexp_ack0", 1, 0);
                else begin e = exp_q0.pop_front(); check("rsp_req0", {rsp_rdata, rsp_resp}, e); end
            end
            if (a01) begin
                ack_log.push_back(1'b1);
                if (exp_q1.size() == 0) check("unexp_ack1", 1, 0);
                else begin e = exp_q1.pop_front(); check("rsp_req1", {rsp_rdata, rsp_resp}, e); end
            end
            if (a10) p_log.push_back(1'b0);
            if (a11) p_log.push_back(1'b1);
            if (awvalid && awready && exp_aw_q.size() > 0) check("awaddr", awaddr, exp_aw_q.pop_front());
            if (wvalid && wready && exp_w_q.size() > 0) check("wdata", wdata, exp_w_q.pop_front());
            if (arvalid && arready && exp_ar_q.size() > 0) check("araddr", araddr, exp_ar_q.pop_front());
            if (aw_pend) check("aw_hold", {awvalid, awaddr}, {1'b1, aw_prev});
            if (w_pend) check("w_hold", {wvalid, wdata}, {1'b1, w_prev});
            if (ar_pend) check("ar_hold", {arvalid, araddr}, {1'b1, ar_prev});
            aw_pend <= awvalid && !awready; aw_prev <= awaddr;
            w_pend  <= wvalid && !wready;   w_prev  <= wdata;
            ar_pend <= arvalid && !arready; ar_prev <= araddr;
            if (arvalid && !arready) ar_stall <= ar_stall + 1;
        end
    end

    // Driver: hold one command until its ack, then release for one cycle.
    task automatic send(input int k, input int n, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [1:0] resp, input bit track, output int lat);
        int i;
        logic [31:0] rexp;
        i = k * 2 + n;
        rexp = wr ? 32'h0 : rd_cfg;
        rw[i] = wr; raddr[i] = addr; rwd[i] = wd; rv[i] = 1'b1;
        if (k == 0) begin
            if (n == 0) exp_q0.push_back({rexp, resp}); else exp_q1.push_back({rexp, resp});
        end
        if (track) begin
            if (wr) begin exp_aw_q.push_back(addr); exp_w_q.push_back(wd); end
            else exp_ar_q.push_back(addr);
        end
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!ack_v[i] && lat < 200);
        check("ack_seen", {31'h0, ack_v[i]}, 1);
        rv[i] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, {a00, a01, busy, grant, awvalid, wvalid, bready, arvalid, rready}, 9'h0);
        check({tag, "_rsp"}, {rsp_rdata, rsp_resp}, 34'h0);
        check({tag, "_aw_w"}, {awaddr, wdata}, 64'h0);
        check({tag, "_ar"}, {32'h0, araddr}, 64'h0);
    endtask

    int lat, b0, b1, s0, l0;
    int aw_t[3] = '{3, 0, 2};
    int w_t[3]  = '{0, 3, 2};
    logic [1:0] br_t[3] = '{2'b00, 2'b11, 2'b00};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        rv = 4'h0; rw = 4'h0;
        for (int i = 0; i < 4; i++) begin raddr[i] = 32'h0; rwd[i] = 32'h0; end
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        check("reset_state", {61'h0, dbg_state}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic write then read, zero-wait slave
        send(0, 0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b00, 1'b1, lat);
        check("wr_latency", lat, 3);
        rd_cfg = 32'h12345678;
        send(0, 1, 1'b0, 32'h20, 32'h0, 2'b00, 1'b1, lat);
        check("rd_latency", lat, 3);

        // Both requesters continuously pending, round-robin
        l0 = ack_log.size();
        fork
            begin
                send(0, 0, 1'b1, 32'h100, 32'hA0A0_0001, 2'b00, 1'b0, lat);
                send(0, 0, 1'b1, 32'h104, 32'hA0A0_0002, 2'b00, 1'b0, lat);
            end
            begin
                send(0, 1, 1'b1, 32'h200, 32'hB0B0_0001, 2'b00, 1'b0, lat);
                send(0, 1, 1'b1, 32'h204, 32'hB0B0_0002, 2'b00, 1'b0, lat);
            end
        join
        check("rr_count", ack_log.size() - l0, 4);
        for (int i = 0; i < 4; i++)
            if (ack_log.size() > l0 + i) check("rr_order", {63'h0, ack_log[l0 + i]}, i % 2);

        // Fixed priority: req0 wins until it stops requesting
        fork
            begin
                for (int i = 0; i < 3; i++) send(1, 0, 1'b0, 32'h300 + i, 32'h0, 2'b00, 1'b0, lat);
            end
            send(1, 1, 1'b0, 32'h400, 32'h0, 2'b00, 1'b0, lat);
        join
        check("fp_count", p_log.size(), 4);
        for (int i = 0; i < 4; i++)
            if (p_log.size() > i) check("fp_order", {63'h0, p_log[i]}, (i == 3) ? 1 : 0);

        // AW/W readiness in either order and together
        for (int t = 0; t < 3; t++) begin
            aw_dly = aw_t[t]; w_dly = w_t[t]; b_cfg = br_t[t];
            b0 = aw_beats; b1 = w_beats;
            send(0, t % 2, 1'b1, 32'h500 + 32'(t * 4), $urandom, br_t[t], 1'b1, lat);
            check("aw_beats", aw_beats - b0, 1);
            check("w_beats", w_beats - b1, 1);
        end
        aw_dly = 0; w_dly = 0; b_cfg = 2'b00;

        // Read with arready stalled 5 cycles and SLVERR
        ar_dly = 5; r_cfg = 2'b10; rd_cfg = 32'hCAFE_0005;
        s0 = ar_stall;
        send(0, 0, 1'b0, 32'h600, 32'h0, 2'b10, 1'b1, lat);
        check("ar_stall_cycles", ar_stall - s0, 5);
        ar_dly = 0; r_cfg = 2'b00;

        // Reset asserted while waiting for the write response
        l0 = ack_log.size();
        rw[0] = 1'b1; raddr[0] = 32'h700; rwd[0] = 32'h5555_AAAA; rv[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_state", {60'h0, busy, dbg_state}, {60'h0, 1'b1, 3'd2});
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        rv[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("no_ack_after_rst", ack_log.size() - l0, 0);
        send(0, 1, 1'b1, 32'h800, 32'h0BAD_F00D, 2'b00, 1'b1, lat);
        check("post_rst_latency", lat, 3);

        repeat (2) @(posedge clk);
        check("exp_queues_empty", exp_q0.size() + exp_q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
